counter_arbiter: RTL

Round-robin controller that shares one synchronous WIDTH-bit run counter between NREQ requesters. Each requester asks for a timed count run of its own length. The block grants the counter to one requester at a time, steps the counter to that requester's terminal count, and signals completion. It sits between the counter datapath and client logic that needs exclusive, timed use of it.

---
 rtl/counter_arbiter_if.sv | 24 ++
 rtl/counter_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/counter_arbiter_if.sv
// Client-side bundle for counter_arbiter: request/length/stall in,
// grant/busy/count/done out.
interface counter_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  stall;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;

    modport master (
        output req, len, stall,
        input  grant, busy, count, done
    );

    modport slave (
        input  req, len, stall,
        output grant, busy, count, done
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared WIDTH-bit run counter among NREQ clients.
// Define COUNTER_ARB_STALL_EN to honour the stall input during RUN.
module counter_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             reset,
    counter_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_tc;
    logic [WIDTH-1:0] r_count;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;

    state_t           w_state;
    logic [PW-1:0]    w_owner;
    logic [PW-1:0]    w_ptr;
    logic [WIDTH-1:0] w_tc;
    logic [WIDTH-1:0] w_count;
    logic [NREQ-1:0]  w_grant;
    logic [NREQ-1:0]  w_done;
    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_inc;
    logic             w_stall;

`ifdef COUNTER_ARB_STALL_EN
    assign w_stall = bus.stall;
`else
    logic w_stall_unused;
    assign w_stall_unused = bus.stall;
    assign w_stall = 1'b0;
`endif

    // First requester at or above ptr, wrapping past NREQ-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[(int'(r_ptr) + i) % NREQ]) begin
                w_found = 1'b1;
                w_win   = PW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_ptr_inc = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_tc    = r_tc;
        w_count = r_count;
        w_grant = r_grant;
        w_done  = '0;
        unique case (r_state)
            S_IDLE: begin
                w_grant = '0;
                if (w_found) begin
                    w_state = S_RUN;
                    w_owner = w_win;
                    w_tc    = bus.len[int'(w_win)*WIDTH +: WIDTH];
                    w_count = '0;
                    w_grant = NREQ'(1) << w_win;
                end
            end
            S_RUN: begin
                if (!bus.req[r_owner]) begin
                    w_state = S_IDLE;
                    w_grant = '0;
                    w_count = '0;
                    w_ptr   = w_ptr_inc;
                end else if (w_stall) begin
                    w_count = r_count;
                end else if (r_count == r_tc) begin
                    w_state          = S_DONE;
                    w_done[r_owner]  = 1'b1;
                end else begin
                    w_count = r_count + WIDTH'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_count = '0;
                w_ptr   = w_ptr_inc;
            end
            default: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_tc    <= '0;
            r_count <= '0;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_tc    <= w_tc;
            r_count <= w_count;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_busy  <= |w_grant;
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;
    assign bus.count = r_count;
    assign bus.done  = r_done;
endmodule
